// File: rtl/aes_gcm_tag_verify_if.sv
// Bus bundle for the GCM receive-side tag checker: per-instance parameters,
// the block stream handshake and the completion/result signals.
interface aes_gcm_tag_verify_if;
    logic         i_start;
    logic [127:0] i_h;
    logic [127:0] i_ej0;
    logic [127:0] i_tag;
    logic [63:0]  i_aad_len;
    logic [63:0]  i_ct_len;
    logic         i_blk_valid;
    logic [127:0] i_blk;
    logic         o_blk_ready;
    logic         o_busy;
    logic         o_done;
    logic [127:0] o_tag;
    logic         o_tag_ok;

    // Caller side: launches instances and streams blocks.
    modport master (
        output i_start, i_h, i_ej0, i_tag, i_aad_len, i_ct_len, i_blk_valid, i_blk,
        input  o_blk_ready, o_busy, o_done, o_tag, o_tag_ok
    );

    // Tag checker side.
    modport slave (
        input  i_start, i_h, i_ej0, i_tag, i_aad_len, i_ct_len, i_blk_valid, i_blk,
        output o_blk_ready, o_busy, o_done, o_tag, o_tag_ok
    );
endinterface

// File: rtl/aes_gcm_tag_verify.sv
// GCM decrypt-side tag check. GHASH over AAD and CT blocks plus the length
// block, using an iterative digit-serial GF(2^128) multiplier, then
// T' = GHASH ^ E(K,J0) compared against the received tag.
// GCM bit i of every 128-bit vector is held at index [127-i] (bit 0 = MSB).
module aes_gcm_tag_verify #(
    parameter int DIGIT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_gcm_tag_verify_if.slave  bus
);
    localparam int M  = 128 / DIGIT_BITS;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [127:0] R = {8'hE1, 120'd0};

    typedef enum logic [2:0] {IDLE, ABSORB, MULT, LENBLK, DONE} state_t;

    state_t         state;
    logic [127:0]   h_q;
    logic [127:0]   ej0_q;
    logic [127:0]   tag_q;
    logic [63:0]    aad_len_q;
    logic [63:0]    ct_len_q;
    logic [127:0]   y_q;
    logic [127:0]   z_q;
    logic [127:0]   v_q;
    logic [57:0]    nblk_q;
    logic [CW-1:0]  mcnt_q;
    logic           len_done_q;
    logic           blk_ready_q;
    logic           busy_q;
    logic           done_q;
    logic [127:0]   tag_out_q;
    logic           tag_ok_q;

    logic [127:0]   z_nx;
    logic [127:0]   v_nx;
    logic [127:0]   t_nx;
    logic [57:0]    nblk_start;
    logic           mult_last;

    // Number of 128-bit blocks covering a bit length (rounded up).
    function automatic logic [57:0] blocks_of(input logic [63:0] len);
        return {1'b0, len[63:7]} + {57'd0, |len[6:0]};
    endfunction

    assign nblk_start = blocks_of(bus.i_aad_len) + blocks_of(bus.i_ct_len);
    assign mult_last  = (mcnt_q == CW'(M - 1));
    assign t_nx       = z_nx ^ ej0_q;

    // One digit of the shift-and-add multiply; the multiplier operand is
    // consumed from the top of y_q, which is shifted left after each digit.
    always_comb begin
        z_nx = z_q;
        v_nx = v_q;
        for (int j = 0; j < DIGIT_BITS; j++) begin
            if (y_q[127 - j]) z_nx = z_nx ^ v_nx;
            v_nx = {1'b0, v_nx[127:1]} ^ (v_nx[0] ? R : 128'd0);
        end
    end

    // Control FSM with GHASH datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            h_q         <= '0;
            ej0_q       <= '0;
            tag_q       <= '0;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            y_q         <= '0;
            z_q         <= '0;
            v_q         <= '0;
            nblk_q      <= '0;
            mcnt_q      <= '0;
            len_done_q  <= 1'b0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag_out_q   <= '0;
            tag_ok_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        h_q        <= bus.i_h;
                        ej0_q      <= bus.i_ej0;
                        tag_q      <= bus.i_tag;
                        aad_len_q  <= bus.i_aad_len;
                        ct_len_q   <= bus.i_ct_len;
                        y_q        <= '0;
                        nblk_q     <= nblk_start;
                        len_done_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (nblk_start != '0) begin
                            state       <= ABSORB;
                            blk_ready_q <= 1'b1;
                        end else begin
                            state <= LENBLK;
                        end
                    end
                end
                ABSORB: begin
                    if (bus.i_blk_valid) begin
                        y_q         <= y_q ^ bus.i_blk;
                        nblk_q      <= nblk_q - 58'd1;
                        z_q         <= '0;
                        v_q         <= h_q;
                        mcnt_q      <= '0;
                        blk_ready_q <= 1'b0;
                        state       <= MULT;
                    end
                end
                LENBLK: begin
                    y_q        <= y_q ^ {aad_len_q, ct_len_q};
                    len_done_q <= 1'b1;
                    z_q        <= '0;
                    v_q        <= h_q;
                    mcnt_q     <= '0;
                    state      <= MULT;
                end
                MULT: begin
                    z_q <= z_nx;
                    v_q <= v_nx;
                    if (mult_last) begin
                        y_q <= z_nx;
                        if (nblk_q != '0) begin
                            state       <= ABSORB;
                            blk_ready_q <= 1'b1;
                        end else if (!len_done_q) begin
                            state <= LENBLK;
                        end else begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            tag_out_q <= t_nx;
                            tag_ok_q  <= (t_nx == tag_q);
                        end
                    end else begin
                        y_q    <= y_q << DIGIT_BITS;
                        mcnt_q <= mcnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_blk_ready = blk_ready_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_tag       = tag_out_q;
    assign bus.o_tag_ok    = tag_ok_q;
endmodule

// File: tb/tb_aes_gcm_tag_verify.sv
// Directed bench for aes_gcm_tag_verify: NIST GCM TC1/TC2, tag mismatch,
// stalls, ignored starts, mid-run reset, back-to-back instances and three
// digit widths driven with the same stimulus.
module tb_aes_gcm_tag_verify;
    localparam logic [127:0] H_K0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EJ0   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] CT1   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TAG2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         st = 1'b0;
    logic [127:0] hh = '0;
    logic [127:0] ej = '0;
    logic [127:0] tg = '0;
    logic [63:0]  al = '0;
    logic [63:0]  cl = '0;
    logic         bv = 1'b0;
    logic [127:0] bk = '0;

    int n_chk  = 0;
    int n_fail = 0;

    int           c8, c1, c128;
    logic [127:0] t8, t1, t128;
    logic         ok8, ok1, ok128;
    logic [127:0] tag_at_start;

    aes_gcm_tag_verify_if if8 ();
    aes_gcm_tag_verify_if if1 ();
    aes_gcm_tag_verify_if if128 ();

    assign if8.i_start = st;   assign if1.i_start = st;   assign if128.i_start = st;
    assign if8.i_h = hh;       assign if1.i_h = hh;       assign if128.i_h = hh;
    assign if8.i_ej0 = ej;     assign if1.i_ej0 = ej;     assign if128.i_ej0 = ej;
    assign if8.i_tag = tg;     assign if1.i_tag = tg;     assign if128.i_tag = tg;
    assign if8.i_aad_len = al; assign if1.i_aad_len = al; assign if128.i_aad_len = al;
    assign if8.i_ct_len = cl;  assign if1.i_ct_len = cl;  assign if128.i_ct_len = cl;
    assign if8.i_blk_valid = bv; assign if1.i_blk_valid = bv; assign if128.i_blk_valid = bv;
    assign if8.i_blk = bk;     assign if1.i_blk = bk;     assign if128.i_blk = bk;

    aes_gcm_tag_verify #(.DIGIT_BITS(8))   dut8   (.clk(clk), .rst(rst), .bus(if8.slave));
    aes_gcm_tag_verify #(.DIGIT_BITS(1))   dut1   (.clk(clk), .rst(rst), .bus(if1.slave));
    aes_gcm_tag_verify #(.DIGIT_BITS(128)) dut128 (.clk(clk), .rst(rst), .bus(if128.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one instance and follow it until the D=8 instance (or all three)
    // report done. Cycle numbers count the i_start edge as cycle 0.
    task automatic run(input logic [127:0] th, input logic [127:0] tej, input logic [127:0] ttag,
                       input logic [63:0] tal, input logic [63:0] tcl, input logic [127:0] tblk,
                       input int stall, input int pulse_at, input bit all3);
        int  n;
        bit  fin;
        c8 = -1; c1 = -1; c128 = -1;
        @(negedge clk);
        tag_at_start = if8.o_tag;
        hh = th; ej = tej; tg = ttag; al = tal; cl = tcl; bk = tblk;
        bv = (stall == 0);
        st = 1'b1;
        @(posedge clk);
        n = 0;
        fin = 0;
        while (!fin && n < 600) begin
            @(negedge clk);
            st = 1'b0;
            if (n == pulse_at) begin
                st = 1'b1; hh = ~th; tg = ~ttag;
            end
            if (n == pulse_at + 1) begin
                hh = th; tg = ttag;
            end
            if (stall > 0 && n == stall) bv = 1'b1;
            if (if8.o_done && c8 < 0) begin
                c8 = n + 1; t8 = if8.o_tag; ok8 = if8.o_tag_ok;
            end
            if (if1.o_done && c1 < 0) begin
                c1 = n + 1; t1 = if1.o_tag; ok1 = if1.o_tag_ok;
            end
            if (if128.o_done && c128 < 0) begin
                c128 = n + 1; t128 = if128.o_tag; ok128 = if128.o_tag_ok;
            end
            fin = all3 ? (c8 >= 0 && c1 >= 0 && c128 >= 0) : (c8 >= 0);
            if (!fin) begin
                @(posedge clk);
                n++;
            end
        end
        bv = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  128'(if8.o_busy), 128'd0);
        chk("rst_ready", 128'(if8.o_blk_ready), 128'd0);
        chk("rst_done",  128'(if8.o_done), 128'd0);
        chk("rst_tag",   if8.o_tag, 128'd0);
        chk("rst_ok",    128'(if8.o_tag_ok), 128'd0);
        rst = 1'b0;

        // TC2 on all three digit widths
        run(H_K0, EJ0, TAG2, 64'd0, 64'd128, CT1, 0, -1, 1'b1);
        chk("d8_cyc",   128'(c8), 128'd35);
        chk("d8_tag",   t8, TAG2);
        chk("d8_ok",    128'(ok8), 128'd1);
        chk("d1_cyc",   128'(c1), 128'd259);
        chk("d1_tag",   t1, TAG2);
        chk("d1_ok",    128'(ok1), 128'd1);
        chk("d128_cyc", 128'(c128), 128'd5);
        chk("d128_tag", t128, TAG2);
        chk("d128_ok",  128'(ok128), 128'd1);

        // TC1: empty AAD and CT
        run(H_K0, EJ0, EJ0, 64'd0, 64'd0, '0, 0, -1, 1'b0);
        chk("tc1_cyc", 128'(c8), 128'd18);
        chk("tc1_tag", t8, EJ0);
        chk("tc1_ok",  128'(ok8), 128'd1);

        // TC2 with received tag bit 127 flipped
        run(H_K0, EJ0, TAG2 ^ 128'd1, 64'd0, 64'd128, CT1, 0, -1, 1'b0);
        chk("bad_cyc", 128'(c8), 128'd35);
        chk("bad_tag", t8, TAG2);
        chk("bad_ok",  128'(ok8), 128'd0);

        // same, block valid delayed by 5 cycles
        run(H_K0, EJ0, TAG2 ^ 128'd1, 64'd0, 64'd128, CT1, 5, -1, 1'b0);
        chk("stall_cyc", 128'(c8), 128'd40);
        chk("stall_tag", t8, TAG2);
        chk("stall_ok",  128'(ok8), 128'd0);

        // stray i_start during MULT with different inputs
        run(H_K0, EJ0, TAG2, 64'd0, 64'd128, CT1, 0, 5, 1'b0);
        chk("pulse_cyc", 128'(c8), 128'd35);
        chk("pulse_tag", t8, TAG2);
        chk("pulse_ok",  128'(ok8), 128'd1);

        // reset asserted mid-MULT
        @(negedge clk);
        hh = H_K0; ej = EJ0; tg = TAG2; al = 64'd0; cl = 64'd128; bk = CT1;
        bv = 1'b1; st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 128'(if8.o_busy), 128'd1);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_busy",  128'(if8.o_busy), 128'd0);
        chk("mid_rst_ready", 128'(if8.o_blk_ready), 128'd0);
        chk("mid_rst_done",  128'(if8.o_done), 128'd0);
        chk("mid_rst_tag",   if8.o_tag, 128'd0);
        chk("mid_rst_ok",    128'(if8.o_tag_ok), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        bv = 1'b0;

        run(H_K0, EJ0, EJ0, 64'd0, 64'd0, '0, 0, -1, 1'b0);
        chk("post_rst_cyc", 128'(c8), 128'd18);
        chk("post_rst_tag", t8, EJ0);
        chk("post_rst_ok",  128'(ok8), 128'd1);

        // back-to-back: TC2, then TC1 one cycle after o_done
        run(H_K0, EJ0, TAG2, 64'd0, 64'd128, CT1, 0, -1, 1'b0);
        chk("b2b_tc2_ok",  128'(ok8), 128'd1);
        chk("b2b_tc2_tag", t8, TAG2);
        run(H_K0, EJ0, EJ0, 64'd0, 64'd0, '0, 0, -1, 1'b0);
        chk("b2b_hold_tag", tag_at_start, TAG2);
        chk("b2b_tc1_cyc",  128'(c8), 128'd18);
        chk("b2b_tc1_tag",  t8, EJ0);
        chk("b2b_tc1_ok",   128'(ok8), 128'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
